// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter driving one handshaked, shared-bus memory port.
// Define WRITE_ALLOCATE_EN to follow every write with a 4-word read of its line.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic        rvalid,
  output logic [15:0] rdata,
  output logic [1:0]  rword,
  output logic        owner,
  output logic        rrqst,
  output logic        wrqst,
  output logic        rdacpt,
  input  logic        rrdy,
  input  logic        rdrdy,
  input  logic        wacpt,
  output logic [15:0] mem_dout,
  output logic        mem_oe,
  input  logic [15:0] mem_din
);

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_ADDR = 4'd1,
    RD_WAIT = 4'd2,
    RD_ACK  = 4'd3,
    WR_ADDR = 4'd4,
    WR_GAP  = 4'd5,
    WR_DATA = 4'd6,
    WR_END  = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     count_q, count_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           prio_q, prio_d;
  logic           owner_q, owner_d;
  logic           we_q, we_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [2:0]     meta_q, meta_d;
  logic [2:0]     sync_q, sync_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic           err_q, err_d;
  logic           rvalid_q, rvalid_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [1:0]     rword_q, rword_d;
  logic           rrqst_q, rrqst_d;
  logic           wrqst_q, wrqst_d;
  logic           rdacpt_q, rdacpt_d;
  logic [15:0]    mem_dout_q, mem_dout_d;
  logic           mem_oe_q, mem_oe_d;
  logic           winner;

  logic rrdy_s, rdrdy_s, wacpt_s;
  assign rrdy_s  = sync_q[0];
  assign rdrdy_s = sync_q[1];
  assign wacpt_s = sync_q[2];

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    meta_d   = {wacpt, rdrdy, rrdy};
    sync_d   = meta_q;
    state_d  = state_q;
    count_d  = count_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = 2'b00;
    err_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rword_d  = rword_q;
    winner   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            winner = prio_q;
          end else begin
            winner = req[1];
          end
          owner_d = winner;
          prio_d  = ~winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
          we_d    = we[winner];
          addr_d  = winner ? addr[31:16]  : addr[15:0];
          wdata_d = winner ? wdata[31:16] : wdata[15:0];
          state_d = we_d ? WR_ADDR : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (rrdy_s) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_WAIT: begin
        if (rdrdy_s) begin
          rdata_d  = mem_din;
          rword_d  = count_q;
          rvalid_d = 1'b1;
          state_d  = RD_ACK;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_ACK: begin
        if (!rdrdy_s) begin
          if (count_q == 2'd3) begin
            count_d = 2'd0;
            state_d = DONE;
          end else begin
            count_d = count_q + 2'd1;
            state_d = RD_WAIT;
          end
        end else begin
          state_d = RD_ACK;
        end
      end
      WR_ADDR: begin
        if (wacpt_s) begin
          state_d = WR_GAP;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_GAP: begin
        if (!wacpt_s) begin
          state_d = WR_DATA;
        end else begin
          state_d = WR_GAP;
        end
      end
      WR_DATA: begin
        if (wacpt_s) begin
          state_d = WR_END;
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_END: begin
        if (!wacpt_s) begin
`ifdef WRITE_ALLOCATE_EN
          state_d = RD_WAIT;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = WR_END;
        end
      end
      DONE: begin
        count_d = 2'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled handshake aborts; progress counter restarts on any state change.
    if ((state_q != IDLE) && (state_q != DONE) && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      state_d  = DONE;
      count_d  = 2'd0;
      err_d    = 1'b1;
      rvalid_d = 1'b0;
    end else begin
      err_d = 1'b0;
    end

    if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
      tmo_d = {TW{1'b0}};
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

`ifdef WRITE_ALLOCATE_EN
    rrqst_d = (state_d == RD_ADDR) || (state_d == WR_ADDR);
`else
    rrqst_d = (state_d == RD_ADDR);
`endif
    wrqst_d  = (state_d == WR_ADDR) || (state_d == WR_DATA);
    rdacpt_d = (state_d == RD_ACK);
    done_d   = (state_d == DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;

    case (state_d)
      RD_ADDR, WR_ADDR: begin
        mem_oe_d   = 1'b1;
        mem_dout_d = addr_d;
      end
      WR_DATA: begin
        mem_oe_d   = 1'b1;
        mem_dout_d = wdata_d;
      end
      default: begin
        mem_oe_d   = 1'b0;
        mem_dout_d = 16'h0000;
      end
    endcase
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      tmo_q      <= {TW{1'b0}};
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      meta_q     <= 3'b000;
      sync_q     <= 3'b000;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 16'h0000;
      rword_q    <= 2'd0;
      rrqst_q    <= 1'b0;
      wrqst_q    <= 1'b0;
      rdacpt_q   <= 1'b0;
      mem_dout_q <= 16'h0000;
      mem_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rword_q    <= rword_d;
      rrqst_q    <= rrqst_d;
      wrqst_q    <= wrqst_d;
      rdacpt_q   <= rdacpt_d;
      mem_dout_q <= mem_dout_d;
      mem_oe_q   <= mem_oe_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rword    = rword_q;
  assign owner    = owner_q;
  assign rrqst    = rrqst_q;
  assign wrqst    = wrqst_q;
  assign rdacpt   = rdacpt_q;
  assign mem_dout = mem_dout_q;
  assign mem_oe   = mem_oe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: handshaking memory model, per-client
// expected-transaction queues and a monitor that checks every DUT response.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  req, we;
  logic [31:0] addr, wdata;
  logic [1:0]  gnt, done;
  logic        err, rvalid, owner, rrqst, wrqst, rdacpt, mem_oe;
  logic [15:0] rdata, mem_dout, mem_din;
  logic [1:0]  rword;
  logic        rrdy, rdrdy, wacpt;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rvalid(rvalid), .rdata(rdata), .rword(rword),
    .owner(owner), .rrqst(rrqst), .wrqst(wrqst), .rdacpt(rdacpt),
    .rrdy(rrdy), .rdrdy(rdrdy), .wacpt(wacpt),
    .mem_dout(mem_dout), .mem_oe(mem_oe), .mem_din(mem_din)
  );

  typedef struct packed {
    logic             client;
    logic             err;
    logic [2:0]       nwords;
    logic [3:0][15:0] words;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;

  txn_t        exp_q0[$];
  txn_t        exp_q1[$];
  int          exp_gnt_q[$];
  logic [15:0] wr_dout_q[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] mdl_mem [logic [15:0]];
  logic        stall = 1'b0;
  logic        saw_both = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents before any write: a fixed function of the address.
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] mdl_rd(input logic [15:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return a ^ 16'hA5C3;
  endfunction

  // Reference model: a read returns the 4 words of the addressed line; a write
  // updates memory (and with write-allocate then returns the updated line).
  task automatic push_exp(input logic c, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic e);
    txn_t t;
    logic do_rd;
    t.client = c; t.err = e; t.nwords = 3'd0; t.words = '0;
    do_rd = !w;
`ifdef WRITE_ALLOCATE_EN
    do_rd = 1'b1;
`endif
    if (w && !e) ref_mem[a] = d;
    if (do_rd && !e) begin
      t.nwords = 3'd4;
      for (int i = 0; i < 4; i++) t.words[i] = ref_rd({a[15:2], i[1:0]});
    end
    if (c) exp_q1.push_back(t); else exp_q0.push_back(t);
  endtask

  task automatic drive(input logic c, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (c) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
  endtask

  task automatic issue(input logic c, input logic w, input logic [15:0] a, input logic [15:0] d);
    push_exp(c, w, a, d, 1'b0);
    drive(c, w, a, d);
  endtask

  task automatic wait_done(input int c, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done[c]) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_done: client %0d saw no done within %0d cycles", c, budget);
  endtask

  task automatic drop(input logic c);
    if (c) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {gnt, done, err, rvalid, rword, owner, rrqst, wrqst, rdacpt, mem_oe}, 32'd0);
    check({name, "_data"}, {rdata, mem_dout}, 32'd0);
  endtask

  // Memory model: 4-phase handshakes with random response delay, updated on negedge.
  int          ms = 0;
  int          md = 0;
  logic [1:0]  widx_m = 2'd0;
  logic [15:0] maddr = 16'h0000;
  logic        alloc = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      ms = 0; rrdy = 1'b0; rdrdy = 1'b0; wacpt = 1'b0; mem_din = 16'h0000;
    end else begin
      case (ms)
        0: if (mem_oe && wrqst) begin
             maddr = mem_dout; alloc = rrqst; md = $urandom_range(0, 3); ms = 7;
           end else if (mem_oe && rrqst && !stall) begin
             maddr = mem_dout; md = $urandom_range(0, 3); ms = 1;
           end
        1: if (md > 0) md--; else begin rrdy = 1'b1; ms = 2; end
        2: if (!rrqst) begin rrdy = 1'b0; widx_m = 2'd0; md = $urandom_range(0, 3); ms = 3; end
        3: if (md > 0) md--;
           else begin mem_din = mdl_rd({maddr[15:2], widx_m}); rdrdy = 1'b1; ms = 4; end
        4: if (rdacpt) begin rdrdy = 1'b0; ms = 5; end
        5: if (!rdacpt) begin
             if (widx_m == 2'd3) ms = 0;
             else begin widx_m = widx_m + 2'd1; md = $urandom_range(0, 3); ms = 3; end
           end
        7: if (md > 0) md--; else begin wacpt = 1'b1; ms = 8; end
        8: if (!wrqst) begin wacpt = 1'b0; ms = 9; end
        9: if (wrqst && mem_oe) begin mdl_mem[maddr] = mem_dout; md = $urandom_range(0, 3); ms = 10; end
        10: if (md > 0) md--; else begin wacpt = 1'b1; ms = 11; end
        11: if (!wrqst) begin
              wacpt = 1'b0;
              if (alloc) begin widx_m = 2'd0; md = $urandom_range(0, 3); ms = 3; end
              else ms = 0;
            end
        default: ms = 0;
      endcase
    end
  end

  // Monitor: pops the granted client's expectation and checks every response.
  txn_t cur;
  logic cur_valid = 1'b0;
  int   widx = 0;
  int   sz = 0;
  int   rq_run = 0;
  int   last_rq_run = 0;
  logic wrqst_prev = 1'b0;
  logic c_mon;
  always @(negedge clk) begin
    if (reset) begin
      cur_valid = 1'b0; rq_run = 0; wrqst_prev = 1'b0;
    end else begin
      if (rrqst) rq_run++;
      else if (rq_run != 0) begin last_rq_run = rq_run; rq_run = 0; end
      if (wrqst && !wrqst_prev) begin
        wr_dout_q.push_back(mem_dout);
        check("wrqst_with_oe", mem_oe, 1);
      end
      wrqst_prev = wrqst;
      if (rrqst && wrqst) saw_both = 1'b1;
      if (rdacpt) check("bus_contention", mem_oe, 0);
      if (gnt != 2'b00) begin
        c_mon = gnt[1];
        check("gnt_onehot", (gnt == 2'b01) || (gnt == 2'b10), 1);
        check("gnt_while_busy", cur_valid, 0);
        check("owner", owner, c_mon);
        if (exp_gnt_q.size() > 0) check("grant_order", c_mon, exp_gnt_q.pop_front());
        sz = c_mon ? exp_q1.size() : exp_q0.size();
        check("gnt_expected", sz != 0, 1);
        if (sz != 0) begin
          cur = c_mon ? exp_q1.pop_front() : exp_q0.pop_front();
          cur_valid = 1'b1;
        end
        widx = 0;
      end
      if (rvalid) begin
        check("rvalid_in_txn", cur_valid, 1);
        if (cur_valid) begin
          check("rvalid_count", widx < cur.nwords, 1);
          if (widx < 4) begin
            check("rword", rword, widx);
            check("rdata", rdata, cur.words[widx]);
          end
          widx++;
        end
      end
      if (done != 2'b00) begin
        check("done_in_txn", cur_valid, 1);
        if (cur_valid) begin
          check("done_client", done, cur.client ? 2'b10 : 2'b01);
          check("err", err, cur.err);
          check("words_seen", widx, cur.nwords);
          if (cur.err) check("timeout_rrqst_cycles", last_rq_run, TMO);
        end
        cur_valid = 1'b0;
      end else if (err) begin
        check("err_without_done", err, 0);
      end
    end
  end

  task automatic rand_client(input logic c);
    logic        w;
    logic [15:0] a, d;
    for (int n = 0; n < 25; n++) begin
      w = 1'($urandom_range(0, 1));
      a = (c ? 16'h8200 : 16'h0200) + 16'($urandom_range(0, 15));
      d = 16'($urandom);
      issue(c, w, a, d);
      wait_done(c, 600);
      drop(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int ndn;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Both clients held: round-robin from client 0.
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(0);
    push_exp(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    push_exp(1'b1, 1'b0, 16'h8020, 16'h0000, 1'b0);
    push_exp(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    drive(1'b0, 1'b0, 16'h0010, 16'h0000);
    drive(1'b1, 1'b0, 16'h8020, 16'h0000);
    ndn = 0;
    for (int k = 0; k < 1500 && ndn < 3; k++) begin
      @(negedge clk);
      if (done != 2'b00) ndn++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_done_count", ndn, 3);
    check("rr_grants_left", exp_gnt_q.size(), 0);
    repeat (2) @(negedge clk);

    // Line read returning 0x5555 x4.
    for (int i = 0; i < 4; i++) begin
      mdl_mem[16'h1234 + 16'(i)] = 16'h5555;
      ref_mem[16'h1234 + 16'(i)] = 16'h5555;
    end
    issue(1'b0, 1'b0, 16'h1234, 16'h0000);
    wait_done(0, 400); drop(1'b0);
    repeat (2) @(negedge clk);

    // Single-word write by client 1, then read back through the arbiter.
    wr_dout_q.delete(); saw_both = 1'b0;
    issue(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    wait_done(1, 400); drop(1'b1);
    check("wr_strobe_count", wr_dout_q.size(), 2);
    check("wr_addr_phase", (wr_dout_q.size() > 0) ? {16'h0000, wr_dout_q[0]} : 32'hFFFF_FFFF, 32'h0000_0040);
    check("wr_data_phase", (wr_dout_q.size() > 1) ? {16'h0000, wr_dout_q[1]} : 32'hFFFF_FFFF, 32'h0000_BEEF);
    check("mem_written", mdl_rd(16'h0040), 16'hBEEF);
`ifdef WRITE_ALLOCATE_EN
    check("alloc_rrqst_wrqst", saw_both, 1);
`else
    check("rrqst_during_write", saw_both, 0);
`endif
    issue(1'b1, 1'b0, 16'h0040, 16'h0000);
    wait_done(1, 400); drop(1'b1);
    repeat (2) @(negedge clk);

    // Memory never answers rrqst: timeout abort with err.
    stall = 1'b1;
    push_exp(1'b0, 1'b0, 16'h0300, 16'h0000, 1'b1);
    drive(1'b0, 1'b0, 16'h0300, 16'h0000);
    wait_done(0, 200); drop(1'b0);
    stall = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_timeout", {rrqst, wrqst, mem_oe}, 3'b000);

    // Reset in RD_ACK after word 1, then a normal transaction.
    issue(1'b0, 1'b0, 16'h0100, 16'h0000);
    ndn = 0;
    for (int k = 0; k < 400 && ndn == 0; k++) begin
      @(negedge clk);
      if (rvalid && (rword == 2'd1)) ndn = 1;
    end
    check("reached_word1", ndn, 1);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_txn");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", done, 2'b00);
    issue(1'b1, 1'b0, 16'h8040, 16'h0000);
    wait_done(1, 400); drop(1'b1);
    repeat (2) @(negedge clk);

`ifdef WRITE_ALLOCATE_EN
    saw_both = 1'b0;
    issue(1'b0, 1'b1, 16'h0102, 16'h1357);
    wait_done(0, 600); drop(1'b0);
    check("alloc_write_strobes", saw_both, 1);
    repeat (2) @(negedge clk);
`endif

    // Random concurrent traffic, disjoint address regions per client.
    fork
      rand_client(1'b0);
      rand_client(1'b1);
    join
    repeat (5) @(negedge clk);
    check("expectations_drained", exp_q0.size() + exp_q1.size(), 0);
    check("no_txn_open", cur_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, clocks with no handshake progress before a transaction is aborted.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req  in  2  per-client request; bit n belongs to client n, level held until done[n].
REQ-005 Port: we  in  2  per-client op select; 1 is a single-word write, 0 is a 4-word line read.
REQ-006 Port: addr  in  32  {addr1,addr0}, 16-bit word address per client.
REQ-007 Port: wdata  in  32  {wdata1,wdata0}, 16-bit write data per client.
REQ-008 Port: gnt  out  2  one-clock pulse when the client's request is accepted.
REQ-009 Port: done  out  2  one-clock pulse when the client's transaction completes or aborts.
REQ-010 Port: err  out  1  one-clock pulse, coincident with done, on timeout abort.
REQ-011 Port: rvalid  out  1  one-clock pulse per captured read word.
REQ-012 Port: rdata  out  16  read word, valid when rvalid=1.
REQ-013 Port: rword  out  2  word index {0..3} of rdata, valid when rvalid=1.
REQ-014 Port: owner  out  1  index of the currently granted client.
REQ-015 Port: rrqst, wrqst, rdacpt  out  1 each  memory request and accept strobes, all registered.
REQ-016 Port: rrdy, rdrdy, wacpt  in  1 each  asynchronous memory strobes.
REQ-017 Port: mem_dout  out  16  value for the shared memory data bus.
REQ-018 Port: mem_oe  out  1  tri-state enable for mem_dout; the top level builds the bus buffer.
REQ-019 Port: mem_din  in  16  sampled shared memory data bus.

Function
REQ-020 rrdy, rdrdy and wacpt each pass through a 2-flop synchronizer; the FSM uses only the synchronized copies.
REQ-021 Only one transaction is in flight at a time; arbitration happens only in IDLE.
REQ-022 Arbitration is round-robin: on simultaneous requests the client not served last wins; after reset client 0 has priority.
REQ-023 On grant, the FSM latches we, addr and wdata of the winner, sets owner, and pulses gnt.
REQ-024 FSM states: IDLE, RD_ADDR, RD_WAIT, RD_ACK, WR_ADDR, WR_GAP, WR_DATA, WR_END, DONE.
REQ-025 RD_ADDR: rrqst=1, mem_oe=1, mem_dout=addr; on rrdy=1 go to RD_WAIT.
REQ-026 RD_WAIT: rrqst=0, mem_oe=0; on rdrdy=1 capture mem_din, pulse rvalid with rword=count, set rdacpt=1, go to RD_ACK.
REQ-027 RD_ACK: hold rdacpt=1 until rdrdy=0, then rdacpt=0; if count=3 go to DONE, else increment count and go to RD_WAIT.
REQ-028 WR_ADDR: wrqst=1, mem_oe=1, mem_dout=addr; on wacpt=1 go to WR_GAP.
REQ-029 WR_GAP: wrqst=0, mem_oe=0; on wacpt=0 go to WR_DATA.
REQ-030 WR_DATA: wrqst=1, mem_oe=1, mem_dout=wdata; on wacpt=1 go to WR_END.
REQ-031 WR_END: wrqst=0, mem_oe=0; on wacpt=0 go to DONE.
REQ-032 DONE: pulse done[owner], clear count, return to IDLE; a request still held is re-arbitrated on the next IDLE cycle.
REQ-033 mem_oe is never 1 while the FSM is in RD_WAIT or RD_ACK, so the bus does not contend with memory drive.
REQ-034 The 2-bit count wraps from 3 to 0 only on entry to DONE.
REQ-035 A per-state progress counter clears on every state change; reaching TIMEOUT_CYC forces all strobes low, mem_oe=0, and a move to DONE with err=1.
REQ-036 Dropping req mid-transaction is ignored; the transaction runs to completion.

Reset
REQ-037 While reset=1 the FSM goes to IDLE and owner=0, count=0, round-robin pointer=0.
REQ-038 While reset=1 all outputs are 0 and the synchronizers clear; a reset mid-transaction aborts without a done pulse.

Configuration
REQ-039 With WRITE_ALLOCATE_EN defined, we=1 with addr[15]... is not used; instead a write asserts rrqst=1 and wrqst=1 together in WR_ADDR.
REQ-040 With WRITE_ALLOCATE_EN defined, WR_END goes to RD_WAIT after wacpt=0 and a 4-word read of the line follows before DONE.
REQ-041 Without WRITE_ALLOCATE_EN, rrqst is never 1 during a write, and a write ends at DONE after WR_END.

Verification
REQ-042 Test: req=01, we=0, addr0=0x1234, memory model returns 0x5555 x4 -> gnt=01, four rvalid pulses with rword 0..3 and rdata 0x5555, then done=01, err=0.
REQ-043 Test: req=10, we=10, addr1=0x0040, wdata1=0xBEEF -> sequence wrqst 1,0,1,0; mem_dout 0x0040 then 0xBEEF; memory location 0x0040 reads back 0xBEEF; done=10.
REQ-044 Test: req=11 held for three transactions -> grant order client 0, 1, 0; done pulses never overlap.
REQ-045 Test: TIMEOUT_CYC=16 and rrdy held at 0 -> after 16 clocks in RD_ADDR, rrqst=0, err=1, done pulse, return to IDLE.
REQ-046 Test: reset=1 during RD_ACK after word 1 -> next clock all outputs are 0, no done pulse, and a new request completes normally.
REQ-047 Test: WRITE_ALLOCATE_EN defined, write to 0x0102 -> rrqst and wrqst both 1 in WR_ADDR, then four rvalid pulses, then a single done.
